// File: rtl/s820_resp_compactor_if.sv
// Handshake/bus bundle between the benchmark harness and the s820 response compactor.
// Signal names follow the compactor's published port list.
interface s820_resp_compactor_if #(
    parameter int WIDTH = 19,
    parameter int CNT_W = 16
);
    logic             START;
    logic             ABORT;
    logic             D_VALID;
    logic [WIDTH-1:0] D_IN;
    logic [WIDTH-1:0] GOLDEN;
    logic             BUSY;
    logic             DONE;
    logic             PASS;
    logic [WIDTH-1:0] SIG;
    logic [CNT_W-1:0] CNT;

    modport master (
        output START, ABORT, D_VALID, D_IN, GOLDEN,
        input  BUSY, DONE, PASS, SIG, CNT
    );

    modport slave (
        input  START, ABORT, D_VALID, D_IN, GOLDEN,
        output BUSY, DONE, PASS, SIG, CNT
    );
endinterface

// File: rtl/s820_resp_compactor.sv
// Galois-form MISR compacting the 19 s820 primary outputs over CYCLES valid captures,
// then comparing the final signature against GOLDEN.
module s820_resp_compactor #(
    parameter int               WIDTH  = 19,
    parameter int               CYCLES = 16,
    parameter int               CNT_W  = 16,
    parameter logic [WIDTH-1:0] POLY   = 19'h00027,
    parameter logic [WIDTH-1:0] SEED   = 19'h00001
) (
    input logic                   CK,
    input logic                   RN,
    s820_resp_compactor_if.slave  bus
);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(CYCLES - 1);

    state_t           state, state_nxt;
    logic [WIDTH-1:0] sig, sig_nxt, sig_upd;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             pass, pass_nxt;

    always_comb sig_upd = {sig[WIDTH-2:0], 1'b0} ^ (sig[WIDTH-1] ? POLY : '0) ^ bus.D_IN;

    always_comb begin
        state_nxt = state;
        sig_nxt   = sig;
        cnt_nxt   = cnt;
        pass_nxt  = pass;
        // ABORT outranks both START and a completing capture
        if (bus.ABORT) begin
            state_nxt = S_IDLE;
            pass_nxt  = 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (bus.START) begin
                        state_nxt = S_RUN;
                        sig_nxt   = SEED;
                        cnt_nxt   = '0;
                        pass_nxt  = 1'b0;
                    end
                end
                S_RUN: begin
                    if (bus.D_VALID) begin
                        sig_nxt = sig_upd;
                        cnt_nxt = cnt + CNT_W'(1);
                        if (cnt == LAST) begin
                            state_nxt = S_DONE;
                            pass_nxt  = (sig_upd == bus.GOLDEN);
                        end
                    end
                end
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge CK or negedge RN) begin
        if (!RN) begin
            state <= S_IDLE;
            sig   <= '0;
            cnt   <= '0;
            pass  <= 1'b0;
        end else begin
            state <= state_nxt;
            sig   <= sig_nxt;
            cnt   <= cnt_nxt;
            pass  <= pass_nxt;
        end
    end

    assign bus.BUSY = (state == S_RUN);
    assign bus.DONE = (state == S_DONE);
    assign bus.PASS = pass;
    assign bus.SIG  = sig;
    assign bus.CNT  = cnt;
endmodule

// File: tb/tb_s820_resp_compactor.sv
// Bench for s820_resp_compactor: three parameterisations share one stimulus stream and
// are each checked against a polynomial-arithmetic reference model.
module tb_s820_resp_compactor;
    localparam int W = 19;
    localparam logic [W-1:0] POLY = 19'h00027;

    logic         CK = 1'b0;
    logic         RN = 1'b0;
    logic         start = 1'b0, abort = 1'b0, dval = 1'b0;
    logic [W-1:0] din = '0, golden = '0;
    int           total = 0;
    int           bad = 0;

    always #5 CK = ~CK;

    s820_resp_compactor_if #(.WIDTH(W), .CNT_W(16)) b4 ();
    s820_resp_compactor_if #(.WIDTH(W), .CNT_W(16)) bf ();
    s820_resp_compactor_if #(.WIDTH(W), .CNT_W(16)) b1 ();

    assign b4.START = start; assign b4.ABORT = abort; assign b4.D_VALID = dval;
    assign b4.D_IN  = din;   assign b4.GOLDEN = golden;
    assign bf.START = start; assign bf.ABORT = abort; assign bf.D_VALID = dval;
    assign bf.D_IN  = din;   assign bf.GOLDEN = golden;
    assign b1.START = start; assign b1.ABORT = abort; assign b1.D_VALID = dval;
    assign b1.D_IN  = din;   assign b1.GOLDEN = golden;

    s820_resp_compactor #(.WIDTH(W), .CYCLES(4), .CNT_W(16), .POLY(POLY), .SEED(19'h00001))
        u4 (.CK(CK), .RN(RN), .bus(b4));
    s820_resp_compactor #(.WIDTH(W), .CYCLES(16), .CNT_W(16), .POLY(POLY), .SEED(19'h40000))
        uf (.CK(CK), .RN(RN), .bus(bf));
    s820_resp_compactor #(.WIDTH(W), .CYCLES(1), .CNT_W(16), .POLY(POLY), .SEED(19'h00005))
        u1 (.CK(CK), .RN(RN), .bus(b1));

    // Model: st 0 = idle, 1 = run, 2 = done
    typedef struct {
        int           st;
        logic [W-1:0] sig;
        logic [15:0]  cnt;
        logic         pass;
    } mdl_t;

    mdl_t m4, mf, m1;

    // Multiply by x modulo x^19 + POLY
    function automatic logic [W-1:0] mulx(input logic [W-1:0] s);
        logic [W:0] t;
        t = {s, 1'b0};
        if (t[W]) t = t ^ {1'b1, POLY};
        return t[W-1:0];
    endfunction

    function automatic mdl_t step(input mdl_t m, input int cycles, input logic [W-1:0] seed);
        mdl_t n;
        n = m;
        if (abort) begin
            n.st = 0; n.pass = 1'b0;
        end else if (m.st != 1) begin
            if (start) begin
                n.st = 1; n.sig = seed; n.cnt = '0; n.pass = 1'b0;
            end
        end else if (dval) begin
            n.sig = mulx(m.sig) ^ din;
            n.cnt = m.cnt + 16'd1;
            if (int'(n.cnt) == cycles) begin
                n.st = 2; n.pass = (n.sig == golden);
            end
        end
        return n;
    endfunction

    function automatic mdl_t mreset();
        mdl_t r;
        r.st = 0; r.sig = '0; r.cnt = '0; r.pass = 1'b0;
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_one(input string tag, input mdl_t m, input logic busy, input logic done,
                           input logic pass, input logic [W-1:0] sig, input logic [15:0] cnt);
        chk({tag, ".busy"}, 32'(busy), 32'(m.st == 1));
        chk({tag, ".done"}, 32'(done), 32'(m.st == 2));
        chk({tag, ".pass"}, 32'(pass), 32'(m.pass));
        chk({tag, ".sig"},  32'(sig),  32'(m.sig));
        chk({tag, ".cnt"},  32'(cnt),  32'(m.cnt));
    endtask

    task automatic check_all(input string tag);
        chk_one({tag, "/c4"},  m4, b4.BUSY, b4.DONE, b4.PASS, b4.SIG, b4.CNT);
        chk_one({tag, "/c16"}, mf, bf.BUSY, bf.DONE, bf.PASS, bf.SIG, bf.CNT);
        chk_one({tag, "/c1"},  m1, b1.BUSY, b1.DONE, b1.PASS, b1.SIG, b1.CNT);
    endtask

    task automatic tick(input string tag);
        @(posedge CK);
        m4 = step(m4, 4, 19'h00001);
        mf = step(mf, 16, 19'h40000);
        m1 = step(m1, 1, 19'h00005);
        #1;
        check_all(tag);
    endtask

    task automatic async_reset(input string tag);
        RN = 1'b0;
        #1;
        m4 = mreset(); mf = mreset(); m1 = mreset();
        check_all(tag);
        #1 RN = 1'b1;
    endtask

    task automatic cap(input string tag, input logic v, input logic [W-1:0] d);
        dval = v; din = d;
        tick(tag);
        dval = 1'b0;
    endtask

    initial begin
        m4 = mreset(); mf = mreset(); m1 = mreset();
        #2 check_all("reset");
        RN = 1'b1;

        // single captures: shift without feedback, then feedback path
        start = 1'b1; tick("start0"); start = 1'b0;
        cap("shift", 1'b1, '0);
        chk("shift_sig_const", 32'(b4.SIG), 32'h00002);
        chk("shift_cnt_const", 32'(b4.CNT), 32'd1);
        chk("fb_sig_const", 32'(bf.SIG), 32'h00027);
        cap("fb2", 1'b1, 19'h00027);

        // mid-run asynchronous reset after 5 captures on the 16-cycle instance
        for (int i = 0; i < 3; i++) cap("pre_rst", 1'b1, W'($urandom));
        #2 async_reset("rst_mid");

        // full run with gaps, matching golden
        golden = 19'h00010;
        start = 1'b1; tick("run_a_start"); start = 1'b0;
        cap("g1", 1'b1, '0); cap("g2", 1'b0, '0); cap("g3", 1'b1, '0);
        cap("g4", 1'b1, '0); cap("g5", 1'b0, 19'h7ffff); cap("g6", 1'b1, '0);
        chk("runa_sig_const", 32'(b4.SIG), 32'h00010);
        chk("runa_done_const", 32'(b4.DONE), 32'd1);
        chk("runa_pass_const", 32'(b4.PASS), 32'd1);
        cap("done_ignore", 1'b1, 19'h12345);

        // restart from DONE, identical stimulus, mismatching golden
        golden = 19'h00011;
        start = 1'b1; tick("restart"); start = 1'b0;
        chk("restart_sig_const", 32'(b4.SIG), 32'h00001);
        chk("restart_busy_const", 32'(b4.BUSY), 32'd1);
        cap("h1", 1'b1, '0); cap("h2", 1'b0, '0); cap("h3", 1'b1, '0);
        cap("h4", 1'b1, '0); cap("h5", 1'b0, 19'h7ffff); cap("h6", 1'b1, '0);
        chk("runb_sig_const", 32'(b4.SIG), 32'h00010);
        chk("runb_pass_const", 32'(b4.PASS), 32'd0);

        // START during RUN is ignored
        start = 1'b1; tick("s_run0"); start = 1'b0;
        cap("s_run1", 1'b1, 19'h00abc);
        start = 1'b1; cap("s_run2", 1'b1, 19'h00def); start = 1'b0;

        // ABORT with START: abort from run, then again while idle
        abort = 1'b1; start = 1'b1; tick("abort_start1"); tick("abort_start2");
        abort = 1'b0; start = 1'b0;
        chk("abort_idle_busy", 32'(b4.BUSY), 32'd0);

        // ABORT on the completing capture
        golden = 19'h00010;
        start = 1'b1; tick("ab_c0"); start = 1'b0;
        for (int i = 0; i < 3; i++) cap("ab_c", 1'b1, '0);
        abort = 1'b1; cap("ab_last", 1'b1, '0); abort = 1'b0;
        chk("ab_done_const", 32'(b4.DONE), 32'd0);
        chk("ab_cnt_const", 32'(b4.CNT), 32'd3);

        // randomized traffic; golden often set to the predicted next signature
        for (int i = 0; i < 400; i++) begin
            start = ($urandom_range(0, 15) == 0);
            abort = ($urandom_range(0, 63) == 0);
            dval  = ($urandom_range(0, 2) != 0);
            din   = W'($urandom);
            golden = $urandom_range(0, 1) ? (mulx(m4.sig) ^ din) : W'($urandom);
            tick("rand");
            if (i == 200) async_reset("rand_rst");
        end
        start = 1'b0; abort = 1'b0; dval = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
